odd_even_sorter: RTL



---
 rtl/sort_pkg.sv | 21 ++
 rtl/sort_layer.sv | 78 +++++++
 rtl/odd_even_sorter.sv | 118 +++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the odd-even transposition sorter.
package sort_pkg;

  // Controller states: waiting for an array, applying layers, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Worst-case number of two-phase layers needed to sort n elements.
  function automatic int passes_max(input int n);
    return (n + 1) / 2;
  endfunction

  // Width of a counter that must hold 0..passes_max(n).
  function automatic int cnt_width(input int n);
    return $clog2(passes_max(n) + 1);
  endfunction

endpackage

// File: rtl/sort_layer.sv
// One odd-even transposition layer: phase A on pairs starting at element 0,
// then phase B on pairs starting at element 1. Purely combinational.
module sort_layer
  import sort_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int ARRAYLENGTH = 10,
  parameter int SIGNED      = 0
) (
  input  logic [DATAWIDTH*ARRAYLENGTH-1:0] in_data,
  input  logic                             desc,
  output logic [DATAWIDTH*ARRAYLENGTH-1:0] out_data,
  output logic                             swap_any
);

  // Swap when the pair is out of order for the requested direction; equal
  // elements never swap, so the sort is stable for identical keys.
  function automatic logic need_swap(input logic [DATAWIDTH-1:0] lo,
                                     input logic [DATAWIDTH-1:0] hi,
                                     input logic                 d);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(lo) > $signed(hi);
      lt = $signed(lo) < $signed(hi);
    end else begin
      gt = lo > hi;
      lt = lo < hi;
    end
    return d ? lt : gt;
  endfunction

  // Separate arrays per stage keep the phase-A -> phase-B chain acyclic.
  logic [DATAWIDTH-1:0]   st0 [ARRAYLENGTH];
  logic [DATAWIDTH-1:0]   st1 [ARRAYLENGTH];
  logic [DATAWIDTH-1:0]   st2 [ARRAYLENGTH];
  logic [ARRAYLENGTH-1:0] swp_a;
  logic [ARRAYLENGTH-1:0] swp_b;

  for (genvar i = 0; i < ARRAYLENGTH; i++) begin : g_io
    assign st0[i]                          = in_data[i*DATAWIDTH +: DATAWIDTH];
    assign out_data[i*DATAWIDTH +: DATAWIDTH] = st2[i];
  end

  // Phase A: element i is the low side of a pair when i is even and has a
  // right neighbour; odd elements are the high side; a trailing even element
  // (odd N) passes through.
  for (genvar i = 0; i < ARRAYLENGTH; i++) begin : g_phase_a
    if ((i % 2) == 0 && (i + 1) < ARRAYLENGTH) begin : g_lo
      assign swp_a[i] = need_swap(st0[i], st0[i+1], desc);
      assign st1[i]   = swp_a[i] ? st0[i+1] : st0[i];
    end else if ((i % 2) == 1) begin : g_hi
      assign swp_a[i] = 1'b0;
      assign st1[i]   = swp_a[i-1] ? st0[i-1] : st0[i];
    end else begin : g_pass
      assign swp_a[i] = 1'b0;
      assign st1[i]   = st0[i];
    end
  end

  // Phase B: pairs start at element 1; element 0 and, for even N, element N-1
  // pass through.
  for (genvar i = 0; i < ARRAYLENGTH; i++) begin : g_phase_b
    if ((i % 2) == 1 && (i + 1) < ARRAYLENGTH) begin : g_lo
      assign swp_b[i] = need_swap(st1[i], st1[i+1], desc);
      assign st2[i]   = swp_b[i] ? st1[i+1] : st1[i];
    end else if ((i % 2) == 0 && i >= 2) begin : g_hi
      assign swp_b[i] = 1'b0;
      assign st2[i]   = swp_b[i-1] ? st1[i-1] : st1[i];
    end else begin : g_pass
      assign swp_b[i] = 1'b0;
      assign st2[i]   = st1[i];
    end
  end

  assign swap_any = (|swp_a) | (|swp_b);

endmodule

// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorter with ready/valid on both sides. One layer per
// clock, early exit when a layer makes no swap, result held until accepted.
module odd_even_sorter
  import sort_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int ARRAYLENGTH = 10,
  parameter int SIGNED      = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATAWIDTH*ARRAYLENGTH-1:0]     in_data,
  input  logic                                 in_desc,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATAWIDTH*ARRAYLENGTH-1:0]     out_data,
  output logic [cnt_width(ARRAYLENGTH)-1:0]    out_passes,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int AW = DATAWIDTH * ARRAYLENGTH;
  localparam int P  = passes_max(ARRAYLENGTH);
  localparam int CW = cnt_width(ARRAYLENGTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   work_q, work_d;
  logic            desc_q, desc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_passes_q, out_passes_d;
  logic            out_valid_q, out_valid_d;

  logic [AW-1:0]   layer_out;
  logic            swap_any;

  sort_layer #(
    .DATAWIDTH  (DATAWIDTH),
    .ARRAYLENGTH(ARRAYLENGTH),
    .SIGNED     (SIGNED)
  ) u_layer (
    .in_data (work_q),
    .desc    (desc_q),
    .out_data(layer_out),
    .swap_any(swap_any)
  );

  // Next-state and datapath updates for the IDLE/SORT/DONE controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    work_d       = work_q;
    desc_d       = desc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_passes_d = out_passes_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          desc_d  = in_desc;
          cnt_d   = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        work_d = layer_out;
        cnt_d  = cnt_q + CW'(1);
        if (!swap_any || cnt_d == CW'(P)) begin
          out_data_d   = layer_out;
          out_passes_d = cnt_d;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any sort in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_passes_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_passes_q <= out_passes_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Working array and direction.
  // NOTE: no reset here; both are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    desc_q <= desc_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_data   = out_data_q;
  assign out_passes = out_passes_q;
  assign out_valid  = out_valid_q;

endmodule
